// File: rtl/gfx_host_bus_initiator.sv
// Host-side master for the graphics adapter register bus.
// Queues read/write commands and replays each one as a single strobed bus cycle.
module gfx_host_bus_initiator #(
   parameter int PHASE_CYCLES = 25,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_we,
   input  logic [3:0] cmd_rs,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       bus_clk_o,
   output logic       cs_o,
   output logic [3:0] rs_o,
   output logic       wren_o,
   output logic [7:0] data_o,
   output logic       data_oe,
   input  logic [7:0] data_i
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(PHASE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [12:0]   mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic [12:0]   head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign pop       = (state == IDLE) && !empty;
   assign head      = mem[rd_ptr[AW-1:0]];
   assign busy      = !empty || (state != IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {cmd_we, cmd_rs, cmd_wdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // wren_o doubles as the read flag of the transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bus_clk_o <= 1'b0;
         cs_o      <= 1'b1;
         rs_o      <= '0;
         wren_o    <= 1'b1;
         data_o    <= '0;
         data_oe   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) begin
                  state   <= SETUP;
                  cnt     <= '0;
                  cs_o    <= 1'b0;
                  rs_o    <= head[11:8];
                  wren_o  <= ~head[12];
                  data_o  <= head[12] ? head[7:0] : 8'h00;
                  data_oe <= head[12];
               end
            end
            SETUP: begin
               if (cnt == LAST) begin
                  cnt       <= '0;
                  state     <= STROBE;
                  bus_clk_o <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STROBE: begin
               if (cnt == LAST) begin
                  cnt       <= '0;
                  state     <= HOLD;
                  bus_clk_o <= 1'b0;
                  if (wren_o) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= data_i;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HOLD: begin
               state   <= IDLE;
               cs_o    <= 1'b1;
               rs_o    <= '0;
               wren_o  <= 1'b1;
               data_o  <= '0;
               data_oe <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gfx_host_bus_initiator.sv
// Self-checking bench for gfx_host_bus_initiator: table-driven single transactions
// plus hand-written back-to-back, full-FIFO, reset-abort and mode-register sequences.
module tb_gfx_host_bus_initiator;

   localparam int P     = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_we;
   logic [3:0] cmd_rs;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       busy;
   logic       bus_clk_o;
   logic       cs_o;
   logic [3:0] rs_o;
   logic       wren_o;
   logic [7:0] data_o;
   logic       data_oe;
   logic [7:0] data_i;
   logic [7:0] readValue = 8'h00;

   gfx_host_bus_initiator #(.PHASE_CYCLES(P), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_we(cmd_we), .cmd_rs(cmd_rs), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .bus_clk_o(bus_clk_o), .cs_o(cs_o), .rs_o(rs_o), .wren_o(wren_o),
      .data_o(data_o), .data_oe(data_oe), .data_i(data_i)
   );

   always #5 clk = ~clk;

   // The adapter only drives read data while selected, reading and strobe high.
   assign data_i = (bus_clk_o && !cs_o && wren_o) ? readValue : 8'h00;

   int testsRun = 0;
   int failures = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Bus monitor: captures writes on the strobe falling edge and watches the glitch rules.
   typedef struct packed {logic [3:0] rs; logic [7:0] data;} wr_t;
   wr_t  writes[$];
   int   periods[$];
   int   lowRuns[$];
   int   cycleCount = 0;
   int   lastFall = -1;
   int   lowRun = 0;
   int   glitchCount = 0;
   int   rspCount = 0;
   logic prevCs = 1'b1, prevBusClk = 1'b0, prevWren = 1'b1, prevOe = 1'b0;
   logic [3:0] prevRs = '0;
   logic [7:0] prevData = '0;

   always @(negedge clk) begin
      cycleCount++;
      if (rsp_valid) rspCount++;
      if (!prevCs && !cs_o && (rs_o !== prevRs || data_o !== prevData || wren_o !== prevWren || data_oe !== prevOe))
         glitchCount++;
      if (prevCs && cs_o && bus_clk_o !== prevBusClk) glitchCount++;
      if (prevBusClk && !bus_clk_o && !cs_o && !wren_o) writes.push_back({rs_o, data_o});
      if (prevCs && !cs_o) begin
         if (lastFall >= 0) periods.push_back(cycleCount - lastFall);
         lastFall = cycleCount;
         lowRun = 0;
      end
      if (!cs_o) lowRun++;
      if (!prevCs && cs_o) lowRuns.push_back(lowRun);
      prevCs = cs_o; prevBusClk = bus_clk_o; prevWren = wren_o;
      prevOe = data_oe; prevRs = rs_o; prevData = data_o;
   end

   task automatic clearMonitor();
      #1;
      writes.delete(); periods.delete(); lowRuns.delete();
      lastFall = -1; rspCount = 0;
   endtask

   task automatic waitIdle(input string name);
      for (int i = 0; i < 300 && busy; i++) @(negedge clk);
      checkOutput(name, busy, 0);
      @(negedge clk);
   endtask

   typedef struct {
      logic       we;
      logic [3:0] rs;
      logic [7:0] wdata;
      logic [7:0] rdval;
      logic       expWren;
      logic [7:0] expData;
      logic       expOe;
      logic       expRsp;
      logic [7:0] expRdata;
   } vec_t;

   vec_t vecs[5];

   // One command through an idle initiator, checked cycle by cycle from pop to cs_o release.
   task automatic applyStimulus(input int n, input vec_t v);
      cmd_valid = 1'b1; cmd_we = v.we; cmd_rs = v.rs; cmd_wdata = v.wdata; readValue = v.rdval;
      checkOutput($sformatf("v%0d_ready", n), cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput($sformatf("v%0d_busy", n), busy, 1);
      checkOutput($sformatf("v%0d_no_bypass", n), cs_o, 1);
      for (int k = 0; k <= 2*P; k++) begin
         @(negedge clk);
         checkOutput($sformatf("v%0d_cs[%0d]", n, k), cs_o, 0);
         checkOutput($sformatf("v%0d_strobe[%0d]", n, k), bus_clk_o, (k >= P && k < 2*P));
         checkOutput($sformatf("v%0d_rs[%0d]", n, k), rs_o, v.rs);
         checkOutput($sformatf("v%0d_wren[%0d]", n, k), wren_o, v.expWren);
         checkOutput($sformatf("v%0d_oe[%0d]", n, k), data_oe, v.expOe);
         if (v.we) checkOutput($sformatf("v%0d_data[%0d]", n, k), data_o, v.expData);
         checkOutput($sformatf("v%0d_rspv[%0d]", n, k), rsp_valid, (k == 2*P) ? v.expRsp : 1'b0);
      end
      checkOutput($sformatf("v%0d_rdata_hold", n), rsp_rdata, v.expRdata);
      @(negedge clk);
      checkOutput($sformatf("v%0d_cs_idle", n), cs_o, 1);
      checkOutput($sformatf("v%0d_strobe_idle", n), bus_clk_o, 0);
      checkOutput($sformatf("v%0d_rspv_idle", n), rsp_valid, 0);
      checkOutput($sformatf("v%0d_rdata_after", n), rsp_rdata, v.expRdata);
      checkOutput($sformatf("v%0d_busy_idle", n), busy, 0);
      checkOutput($sformatf("v%0d_oe_idle", n), data_oe, 0);
      checkOutput($sformatf("v%0d_wren_idle", n), wren_o, 1);
   endtask

   // Six writes offered every cycle: FIFO fills, ready stalls across the pop edge, then recovers.
   task automatic backToBack();
      int   idx = 0;
      int   stall = 0;
      bit   sawStall = 0;
      logic ready;
      clearMonitor();
      for (int cyc = 0; cyc < 200 && idx < 6; cyc++) begin
         cmd_valid = 1'b1; cmd_we = 1'b1;
         cmd_rs = 4'(idx + 2); cmd_wdata = 8'(8'h10 + idx);
         ready = cmd_ready;
         if (!ready) begin
            stall++;
            if (!sawStall) begin
               sawStall = 1;
               checkOutput("b2b_accepts_before_full", idx, 5);
            end
         end
         @(negedge clk);
         if (ready) idx++;
      end
      cmd_valid = 1'b0;
      checkOutput("b2b_total_accepts", idx, 6);
      checkOutput("b2b_stall_cycles", stall, 7);
      waitIdle("b2b_idle");
      checkOutput("b2b_write_count", writes.size(), 6);
      for (int i = 0; i < writes.size() && i < 6; i++) begin
         checkOutput($sformatf("b2b_rs[%0d]", i), writes[i].rs, 4'(i + 2));
         checkOutput($sformatf("b2b_data[%0d]", i), writes[i].data, 8'(8'h10 + i));
      end
      checkOutput("b2b_period_count", periods.size(), 5);
      foreach (periods[i]) checkOutput($sformatf("b2b_period[%0d]", i), periods[i], 2*P + 2);
      foreach (lowRuns[i]) checkOutput($sformatf("b2b_cs_low[%0d]", i), lowRuns[i], 2*P + 1);
   endtask

   task automatic resetAbort();
      int csLowSeen = 0;
      clearMonitor();
      readValue = 8'hC3;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_rs = 4'd3; cmd_wdata = 8'h00;
      @(negedge clk);
      cmd_we = 1'b1; cmd_rs = 4'd5; cmd_wdata = 8'hAA;
      @(negedge clk);
      cmd_rs = 4'd6; cmd_wdata = 8'hBB;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 50 && !bus_clk_o; i++) @(negedge clk);
      checkOutput("rst_strobe_reached", bus_clk_o, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_cs", cs_o, 1);
      checkOutput("rst_strobe", bus_clk_o, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_ready", cmd_ready, 1);
      checkOutput("rst_rspv", rsp_valid, 0);
      checkOutput("rst_oe", data_oe, 0);
      checkOutput("rst_rs", rs_o, 0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!cs_o || bus_clk_o) csLowSeen++;
      end
      checkOutput("rst_no_bus_activity", csLowSeen, 0);
      checkOutput("rst_no_rsp", rspCount, 0);
      checkOutput("rst_no_writes", writes.size(), 0);
      checkOutput("rst_rdata", rsp_rdata, 0);
   endtask

   task automatic modeSequence();
      logic [3:0] expRs[4];
      logic [7:0] expData[4];
      expRs[0] = 4'd0; expData[0] = 8'h00;
      expRs[1] = 4'd3; expData[1] = 8'h12;
      expRs[2] = 4'd4; expData[2] = 8'h05;
      expRs[3] = 4'd1; expData[3] = 8'h48;
      clearMonitor();
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'b1; cmd_we = 1'b1; cmd_rs = expRs[i]; cmd_wdata = expData[i];
         checkOutput($sformatf("mode_ready[%0d]", i), cmd_ready, 1);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      waitIdle("mode_idle");
      checkOutput("mode_write_count", writes.size(), 4);
      for (int i = 0; i < writes.size() && i < 4; i++) begin
         checkOutput($sformatf("mode_rs[%0d]", i), writes[i].rs, expRs[i]);
         checkOutput($sformatf("mode_data[%0d]", i), writes[i].data, expData[i]);
      end
   endtask

   initial begin
      vecs[0] = '{we:1'b1, rs:4'd1,  wdata:8'h41, rdval:8'h00, expWren:1'b0, expData:8'h41, expOe:1'b1, expRsp:1'b0, expRdata:8'h00};
      vecs[1] = '{we:1'b0, rs:4'd3,  wdata:8'h77, rdval:8'h5A, expWren:1'b1, expData:8'h00, expOe:1'b0, expRsp:1'b1, expRdata:8'h5A};
      vecs[2] = '{we:1'b1, rs:4'd15, wdata:8'hFF, rdval:8'h33, expWren:1'b0, expData:8'hFF, expOe:1'b1, expRsp:1'b0, expRdata:8'h5A};
      vecs[3] = '{we:1'b0, rs:4'd0,  wdata:8'h12, rdval:8'hA5, expWren:1'b1, expData:8'h00, expOe:1'b0, expRsp:1'b1, expRdata:8'hA5};
      vecs[4] = '{we:1'b1, rs:4'd9,  wdata:8'h00, rdval:8'h00, expWren:1'b0, expData:8'h00, expOe:1'b1, expRsp:1'b0, expRdata:8'hA5};

      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_rs = '0; cmd_wdata = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_cs", cs_o, 1);
      checkOutput("reset_strobe", bus_clk_o, 0);
      checkOutput("reset_rs", rs_o, 0);
      checkOutput("reset_wren", wren_o, 1);
      checkOutput("reset_data", data_o, 0);
      checkOutput("reset_oe", data_oe, 0);
      checkOutput("reset_rspv", rsp_valid, 0);
      checkOutput("reset_rdata", rsp_rdata, 0);
      checkOutput("reset_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_ready", cmd_ready, 1);

      for (int n = 0; n < 5; n++) applyStimulus(n, vecs[n]);
      checkOutput("single_rsp_count", rspCount, 2);

      backToBack();
      resetAbort();
      modeSequence();
      checkOutput("glitch_rules", glitchCount, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
